// File: rtl/char_buffer_pkg.sv
// char_buffer_pkg
// Shared definitions for the VT52 character/attribute buffer:
//   - erase_cmd encodings (EOL, EOS, ALL, LINE)
//   - erase/scroll engine state type
//   - fill character and DEC graphics glyph range
package char_buffer_pkg;

  localparam logic [1:0] ERASE_EOL  = 2'd0;
  localparam logic [1:0] ERASE_EOS  = 2'd1;
  localparam logic [1:0] ERASE_ALL  = 2'd2;
  localparam logic [1:0] ERASE_LINE = 2'd3;

  typedef enum logic {
    IDLE,
    ERASE
  } state_t;

  localparam logic [7:0] FILL_CHAR = 8'h20;
  localparam logic [7:0] GFX_BASE  = 8'h5F;
  localparam logic [7:0] GFX_LAST  = 8'h7E;

endpackage

// File: rtl/char_attr_ram.sv
// char_attr_ram
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Read-during-write to the same address returns the old contents.
// Contents power up to INIT; the read register clears on reset.
// Ports:
//   clk, reset   clock, synchronous active-high reset (read register only)
//   we/waddr/wdata  write port
//   raddr/rdata     read port, one cycle latency
module char_attr_ram #(
  parameter int unsigned      WIDTH     = 10,
  parameter int unsigned      DEPTH     = 1920,
  parameter int unsigned      ADDR_BITS = 11,
  parameter logic [WIDTH-1:0] INIT      = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH] = '{default: INIT};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/char_attr_buffer.sv
// char_attr_buffer
// Dual-port character/attribute store for the VT52 terminal with hardware
// scroll (circular top-row offset) and a one-cell-per-cycle erase engine.
// Optional feature macro: CHAR_BUFFER_GRAPHICS_EN -- substitutes DEC graphics
// glyph codes (char - 8'h5F) on the read path for cells with attr bit 0 set
// and char in 8'h5F..8'h7E.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wen, wrow, wcol       host write of one cell (din, dattr)
//   rrow, rcol            logical read position, sampled every cycle
//   dout, aout            read character / attribute, one cycle latency
//   scroll                pulse: scroll up one line, then clear last row
//   erase_start/erase_cmd pulse: start erase (EOL/EOS/ALL/LINE)
//   erase_row/erase_col   erase origin
//   busy                  erase/scroll engine active
module char_attr_buffer
  import char_buffer_pkg::*;
#(
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROWS      = 24,
  parameter int unsigned ATTR_BITS = 2,
  parameter int unsigned COL_BITS  = 7,
  parameter int unsigned ROW_BITS  = 5,
  parameter int unsigned ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wen,
  input  logic [ROW_BITS-1:0]  wrow,
  input  logic [COL_BITS-1:0]  wcol,
  input  logic [7:0]           din,
  input  logic [ATTR_BITS-1:0] dattr,
  input  logic [ROW_BITS-1:0]  rrow,
  input  logic [COL_BITS-1:0]  rcol,
  output logic [7:0]           dout,
  output logic [ATTR_BITS-1:0] aout,
  input  logic                 scroll,
  input  logic                 erase_start,
  input  logic [1:0]           erase_cmd,
  input  logic [ROW_BITS-1:0]  erase_row,
  input  logic [COL_BITS-1:0]  erase_col,
  output logic                 busy
);

  localparam int unsigned WIDTH = 8 + ATTR_BITS;
  localparam logic [ROW_BITS:0]   ROWS_W   = (ROW_BITS+1)'(ROWS);
  localparam logic [COL_BITS:0]   COLS_W   = (COL_BITS+1)'(COLS);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [WIDTH-1:0]    FILL_WORD = {FILL_CHAR, {ATTR_BITS{1'b0}}};

  state_t state_q, state_d;
  logic [ROW_BITS-1:0] top_q;
  logic [ROW_BITS-1:0] er_row_q, end_row_q;
  logic [COL_BITS-1:0] er_col_q;
  logic accept_scroll, accept_erase;

  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_waddr, ram_raddr;
  logic [WIDTH-1:0]     ram_wdata, ram_rdata;
  logic                 rd_oor_q;

  logic wr_ok, rd_ok, er_row_ok, er_col_ok, origin_ok;

  // Logical (row, col) to physical address; the row offset wraps by a single
  // conditional subtract since both operands are below ROWS.
  function automatic logic [ADDR_BITS-1:0] map_addr(
    input logic [ROW_BITS-1:0] row,
    input logic [COL_BITS-1:0] col,
    input logic [ROW_BITS-1:0] top
  );
    logic [ROW_BITS:0] prow;
    prow = {1'b0, row} + {1'b0, top};
    if (prow >= ROWS_W) begin
      prow = prow - ROWS_W;
    end
    return ADDR_BITS'(prow) * ADDR_BITS'(COLS) + ADDR_BITS'(col);
  endfunction

  assign wr_ok     = ({1'b0, wrow} < ROWS_W) && ({1'b0, wcol} < COLS_W);
  assign rd_ok     = ({1'b0, rrow} < ROWS_W) && ({1'b0, rcol} < COLS_W);
  assign er_row_ok = ({1'b0, erase_row} < ROWS_W);
  assign er_col_ok = ({1'b0, erase_col} < COLS_W);

  // An out-of-range origin would describe an empty or undefined region, so
  // such requests are dropped rather than started.
  always_comb begin
    origin_ok = 1'b0;
    case (erase_cmd)
      ERASE_ALL:  origin_ok = 1'b1;
      ERASE_LINE: origin_ok = er_row_ok;
      default:    origin_ok = er_row_ok && er_col_ok;
    endcase
  end

  // FSM next-state
  always_comb begin
    state_d       = state_q;
    accept_scroll = 1'b0;
    accept_erase  = 1'b0;
    case (state_q)
      IDLE: begin
        if (scroll) begin
          accept_scroll = 1'b1;
          state_d       = ERASE;
        end else if (erase_start && origin_ok) begin
          accept_erase = 1'b1;
          state_d      = ERASE;
        end
      end
      ERASE: begin
        if (er_col_q == LAST_COL && er_row_q == end_row_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scroll offset and erase cursor
  always_ff @(posedge clk) begin
    if (reset) begin
      top_q     <= '0;
      er_row_q  <= '0;
      er_col_q  <= '0;
      end_row_q <= '0;
    end else if (accept_scroll) begin
      top_q     <= (top_q == LAST_ROW) ? '0 : top_q + 1'b1;
      er_row_q  <= LAST_ROW;
      er_col_q  <= '0;
      end_row_q <= LAST_ROW;
    end else if (accept_erase) begin
      case (erase_cmd)
        ERASE_EOL: begin
          er_row_q  <= erase_row;
          er_col_q  <= erase_col;
          end_row_q <= erase_row;
        end
        ERASE_EOS: begin
          er_row_q  <= erase_row;
          er_col_q  <= erase_col;
          end_row_q <= LAST_ROW;
        end
        ERASE_ALL: begin
          er_row_q  <= '0;
          er_col_q  <= '0;
          end_row_q <= LAST_ROW;
        end
        default: begin
          er_row_q  <= erase_row;
          er_col_q  <= '0;
          end_row_q <= erase_row;
        end
      endcase
    end else if (state_q == ERASE) begin
      if (er_col_q == LAST_COL) begin
        er_col_q <= '0;
        er_row_q <= er_row_q + 1'b1;
      end else begin
        er_col_q <= er_col_q + 1'b1;
      end
    end
  end

  // Write port: engine owns it while busy; writes are held off during reset
  // so an aborted erase leaves no partially-cleared extra cell.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = FILL_WORD;
    if (state_q == ERASE) begin
      ram_we    = !reset;
      ram_waddr = map_addr(er_row_q, er_col_q, top_q);
    end else begin
      ram_we    = wen && wr_ok && !reset;
      ram_waddr = map_addr(wrow, wcol, top_q);
      ram_wdata = {din, dattr};
    end
  end

  assign ram_raddr = rd_ok ? map_addr(rrow, rcol, top_q) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_oor_q <= 1'b0;
    end else begin
      rd_oor_q <= !rd_ok;
    end
  end

  char_attr_ram #(
    .WIDTH    (WIDTH),
    .DEPTH    (COLS * ROWS),
    .ADDR_BITS(ADDR_BITS),
    .INIT     (FILL_WORD)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // Read-path formatting
  always_comb begin
    if (rd_oor_q) begin
      dout = FILL_CHAR;
      aout = '0;
    end else begin
      dout = ram_rdata[ATTR_BITS +: 8];
      aout = ram_rdata[ATTR_BITS-1:0];
`ifdef CHAR_BUFFER_GRAPHICS_EN
      if (ram_rdata[0] && ram_rdata[ATTR_BITS +: 8] >= GFX_BASE &&
          ram_rdata[ATTR_BITS +: 8] <= GFX_LAST) begin
        dout = ram_rdata[ATTR_BITS +: 8] - GFX_BASE;
      end
`else
`endif
    end
  end

  assign busy = (state_q == ERASE);

endmodule
